// File: rtl/sq_cbrt_sum.sv
// sq_cbrt_sum: y = a*a + floor(cbrt(b)) using a shift-add squarer and a bitwise cube-root unit.
// Define SQ_CBRT_SUM_PARALLEL_EN to run both units concurrently for lower latency.
module sq_cbrt_sum #(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               start_i,
  output logic               busy_o,
  output logic               valid_o,
  output logic [2*WIDTH-1:0] y_bo
);
  localparam int K   = (WIDTH + 2) / 3;
  localparam int NCR = 3 * K;
  localparam int XW  = WIDTH + 2 * K + 3;
  localparam int CW  = 6;
  localparam int YW  = 2 * WIDTH;

`ifdef SQ_CBRT_SUM_PARALLEL_EN
  typedef enum logic [1:0] {IDLE, RUN, SUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, SQ, CR, SUM} state_t;
`endif
  state_t state;

  logic [YW-1:0]    mcand;
  logic [YW-1:0]    prod;
  logic [YW-1:0]    sum_q;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    mul_cnt;
  logic [CW-1:0]    cr_cnt;
  logic [CW-1:0]    cr_sh;
  logic [XW-1:0]    cr_x;
  logic [XW-1:0]    cr_y;
  logic [XW-1:0]    cr_ysq;
  logic [XW-1:0]    cr_t;
  logic [1:0]       cr_phase;
  logic             sum_phase;

  logic             mul_en;
  logic             cr_en;
  logic             mul_last;
  logic             cr_last;
  logic [XW-1:0]    cr_base;
  logic [XW-1:0]    cr_trial;
  logic             cr_fits;

  // Trial term for the next root bit is 3*y*(y+1)+1, built from y and y^2 without a multiplier
  always_comb begin
    mul_last = (mul_cnt >= CW'(WIDTH - 1));
    cr_last  = (cr_cnt >= CW'(NCR - 1));
`ifdef SQ_CBRT_SUM_PARALLEL_EN
    mul_en   = (state == RUN) && (mul_cnt != CW'(WIDTH));
    cr_en    = (state == RUN) && (cr_cnt != CW'(NCR));
`else
    mul_en   = (state == SQ);
    cr_en    = (state == CR);
`endif
    cr_base  = cr_ysq + cr_y;
    cr_trial = (cr_base << 1) + cr_base + XW'(1);
    cr_fits  = ((cr_x >> cr_sh) >= cr_t);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      busy_o    <= 1'b0;
      valid_o   <= 1'b0;
      y_bo      <= '0;
      mcand     <= '0;
      prod      <= '0;
      sum_q     <= '0;
      mplier    <= '0;
      mul_cnt   <= '0;
      cr_cnt    <= '0;
      cr_sh     <= '0;
      cr_x      <= '0;
      cr_y      <= '0;
      cr_ysq    <= '0;
      cr_t      <= '0;
      cr_phase  <= '0;
      sum_phase <= 1'b0;
    end else begin
      valid_o <= 1'b0;

      if (mul_en) begin
        if (mplier[0]) prod <= prod + mcand;
        mcand   <= mcand << 1;
        mplier  <= mplier >> 1;
        mul_cnt <= mul_cnt + CW'(1);
      end

      // Three cycles per root bit: double y, form the trial term, then compare and subtract
      if (cr_en) begin
        cr_cnt <= cr_cnt + CW'(1);
        case (cr_phase)
          2'd0: begin
            cr_y     <= cr_y << 1;
            cr_ysq   <= cr_ysq << 2;
            cr_phase <= 2'd1;
          end
          2'd1: begin
            cr_t     <= cr_trial;
            cr_phase <= 2'd2;
          end
          default: begin
            if (cr_fits) begin
              cr_x   <= cr_x - (cr_t << cr_sh);
              cr_y   <= cr_y + XW'(1);
              cr_ysq <= cr_ysq + (cr_y << 1) + XW'(1);
            end
            cr_sh    <= cr_sh - CW'(3);
            cr_phase <= 2'd0;
          end
        endcase
      end

      case (state)
        IDLE: begin
          if (start_i) begin
            mcand     <= YW'(a_i);
            mplier    <= a_i;
            prod      <= '0;
            mul_cnt   <= '0;
            cr_x      <= XW'(b_i);
            cr_y      <= '0;
            cr_ysq    <= '0;
            cr_t      <= '0;
            cr_sh     <= CW'(3 * (K - 1));
            cr_phase  <= '0;
            cr_cnt    <= '0;
            sum_phase <= 1'b0;
            busy_o    <= 1'b1;
`ifdef SQ_CBRT_SUM_PARALLEL_EN
            state     <= RUN;
`else
            state     <= SQ;
`endif
          end
        end
`ifdef SQ_CBRT_SUM_PARALLEL_EN
        RUN: if (mul_last && cr_last) state <= SUM;
`else
        SQ: if (mul_last) state <= CR;
        CR: if (cr_last) state <= SUM;
`endif
        SUM: begin
          if (!sum_phase) begin
            sum_q     <= prod + YW'(cr_y);
            sum_phase <= 1'b1;
          end else begin
            y_bo      <= sum_q;
            busy_o    <= 1'b0;
            valid_o   <= 1'b1;
            sum_phase <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
